// File: rtl/bcd_to_seven_seg.sv
// rtl/bcd_to_seven_seg.sv - registered BCD to 7-segment decoder with blank, lamp test and invalid flag
module bcd_to_seven_seg #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] BCD_in,
    input  logic       blank,
    input  logic       lamp_test,
    output logic [6:0] sevenSeg,
    output logic       invalid
);

    // Active-high patterns, bit0=a .. bit6=g
    localparam logic [6:0] SEG_ALL_ON  = 7'h7F;
    localparam logic [6:0] SEG_ALL_OFF = 7'h00;

    // Reset / blank value seen on the pins after polarity is applied
    localparam logic [6:0] PIN_ALL_OFF = ACTIVE_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;

    logic [6:0] digit_pattern;
    logic [6:0] active_pattern;
    logic [6:0] next_seg;
    logic       next_invalid;

    // Digit lookup; codes 10-15 show a blank digit so the output is never undefined
    always_comb begin
        digit_pattern = SEG_ALL_OFF;
        case (BCD_in)
            4'd0:    digit_pattern = 7'h3F;
            4'd1:    digit_pattern = 7'h06;
            4'd2:    digit_pattern = 7'h5B;
            4'd3:    digit_pattern = 7'h4F;
            4'd4:    digit_pattern = 7'h66;
            4'd5:    digit_pattern = 7'h6D;
            4'd6:    digit_pattern = 7'h7D;
            4'd7:    digit_pattern = 7'h07;
            4'd8:    digit_pattern = 7'h7F;
            4'd9:    digit_pattern = 7'h6F;
            default: digit_pattern = SEG_ALL_OFF;
        endcase
    end

    // Lamp test beats blank, blank beats the decoded digit; then apply board polarity
    always_comb begin
        active_pattern = digit_pattern;
        if (lamp_test) begin
            active_pattern = SEG_ALL_ON;
        end else if (blank) begin
            active_pattern = SEG_ALL_OFF;
        end
        next_seg     = ACTIVE_LOW ? ~active_pattern : active_pattern;
        next_invalid = (BCD_in > 4'd9);
    end

    // Output register: one cycle latency, async reset to all segments off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sevenSeg <= PIN_ALL_OFF;
            invalid  <= 1'b0;
        end else begin
            sevenSeg <= next_seg;
            invalid  <= next_invalid;
        end
    end

endmodule

// File: tb/tb_bcd_to_seven_seg.sv
// tb/tb_bcd_to_seven_seg.sv - scoreboard bench for bcd_to_seven_seg in both polarities
module tb_bcd_to_seven_seg;

    logic       clk;
    logic       rst_n;
    logic [3:0] BCD_in;
    logic       blank;
    logic       lamp_test;
    logic [6:0] seg_al;
    logic       inv_al;
    logic [6:0] seg_ah;
    logic       inv_ah;

    int vectors;
    int miscompares;

    logic [6:0] q_al[$];
    logic [6:0] q_ah[$];
    logic       q_inv[$];

    bcd_to_seven_seg #(.ACTIVE_LOW(1'b1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .BCD_in(BCD_in), .blank(blank),
        .lamp_test(lamp_test), .sevenSeg(seg_al), .invalid(inv_al)
    );

    bcd_to_seven_seg #(.ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk(clk), .rst_n(rst_n), .BCD_in(BCD_in), .blank(blank),
        .lamp_test(lamp_test), .sevenSeg(seg_ah), .invalid(inv_ah)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: active-high gfedcba patterns, inverted for active-low
    function automatic logic [6:0] exp_seg(input logic [3:0] bcd, input logic bl,
                                           input logic lt, input logic al);
        logic [6:0] tab [10];
        logic [6:0] p;
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (lt)            p = 7'h7F;
        else if (bl)       p = 7'h00;
        else if (bcd < 10) p = tab[bcd];
        else               p = 7'h00;
        return al ? ~p : p;
    endfunction

    // Drive one vector on the falling edge, queue its expectation, advance past the next rising edge
    task automatic apply(input logic [3:0] bcd, input logic bl, input logic lt);
        @(negedge clk);
        BCD_in    = bcd;
        blank     = bl;
        lamp_test = lt;
        q_al.push_back(exp_seg(bcd, bl, lt, 1'b1));
        q_ah.push_back(exp_seg(bcd, bl, lt, 1'b0));
        q_inv.push_back(bcd > 4'd9);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] e_al, e_ah;
        logic       e_inv;
        rst_n = 1'b0; BCD_in = 4'd8; blank = 1'b0; lamp_test = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (seg_al !== 7'h7F || inv_al !== 1'b0 || seg_ah !== 7'h00 || inv_ah !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: al=%h/%b ah=%h/%b required al=7f/0 ah=00/0",
                     seg_al, inv_al, seg_ah, inv_ah);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'd8, 1'b0, 1'b0);
        e_al = q_al.pop_front(); e_ah = q_ah.pop_front(); e_inv = q_inv.pop_front();
        vectors++;
        if (seg_al !== e_al || seg_ah !== e_ah || inv_al !== e_inv || inv_ah !== e_inv) begin
            miscompares++;
            $display("FAIL reset_release: al=%h ah=%h inv=%b/%b required al=%h ah=%h inv=%b",
                     seg_al, seg_ah, inv_al, inv_ah, e_al, e_ah, e_inv);
        end
    endtask

    task automatic test_sweep();
        logic [6:0] lit_al [10];
        logic [6:0] e_al, e_ah;
        logic       e_inv;
        lit_al = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int i = 0; i < 10; i++) begin
            apply(4'(i), 1'b0, 1'b0);
            e_al = q_al.pop_front(); e_ah = q_ah.pop_front(); e_inv = q_inv.pop_front();
            vectors++;
            if (seg_al !== e_al || seg_al !== lit_al[i] || seg_ah !== e_ah ||
                inv_al !== e_inv || inv_ah !== e_inv) begin
                miscompares++;
                $display("FAIL sweep digit %0d: al=%h ah=%h inv=%b/%b required al=%h ah=%h inv=%b",
                         i, seg_al, seg_ah, inv_al, inv_ah, e_al, e_ah, e_inv);
            end
        end
    endtask

    task automatic test_invalid();
        logic [3:0] codes [3];
        logic [6:0] e_al, e_ah;
        logic       e_inv;
        codes = '{4'd10, 4'd14, 4'd3};
        for (int i = 0; i < 3; i++) begin
            apply(codes[i], 1'b0, 1'b0);
            e_al = q_al.pop_front(); e_ah = q_ah.pop_front(); e_inv = q_inv.pop_front();
            vectors++;
            if (seg_al !== e_al || seg_ah !== e_ah || inv_al !== e_inv || inv_ah !== e_inv) begin
                miscompares++;
                $display("FAIL invalid code %0d: al=%h ah=%h inv=%b/%b required al=%h ah=%h inv=%b",
                         codes[i], seg_al, seg_ah, inv_al, inv_ah, e_al, e_ah, e_inv);
            end
        end
    endtask

    task automatic test_overrides();
        logic [3:0] bcd [5];
        logic       bl  [5];
        logic       lt  [5];
        logic [6:0] e_al, e_ah;
        logic       e_inv;
        bcd = '{4'd5, 4'd5, 4'd12, 4'd0, 4'd15};
        bl  = '{1'b1, 1'b1, 1'b0,  1'b1, 1'b1};
        lt  = '{1'b0, 1'b1, 1'b1,  1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            apply(bcd[i], bl[i], lt[i]);
            e_al = q_al.pop_front(); e_ah = q_ah.pop_front(); e_inv = q_inv.pop_front();
            vectors++;
            if (seg_al !== e_al || seg_ah !== e_ah || inv_al !== e_inv || inv_ah !== e_inv) begin
                miscompares++;
                $display("FAIL override %0d (bcd=%0d bl=%b lt=%b): al=%h ah=%h inv=%b/%b required al=%h ah=%h inv=%b",
                         i, bcd[i], bl[i], lt[i], seg_al, seg_ah, inv_al, inv_ah, e_al, e_ah, e_inv);
            end
        end
    endtask

    task automatic test_polarity();
        logic [3:0] bcd [4];
        logic [6:0] lit_ah [4];
        logic [6:0] e_al, e_ah;
        logic       e_inv;
        bcd    = '{4'd0, 4'd1, 4'd9, 4'd15};
        lit_ah = '{7'h3F, 7'h06, 7'h6F, 7'h00};
        for (int i = 0; i < 4; i++) begin
            apply(bcd[i], 1'b0, 1'b0);
            e_al = q_al.pop_front(); e_ah = q_ah.pop_front(); e_inv = q_inv.pop_front();
            vectors++;
            if (seg_ah !== lit_ah[i] || seg_ah !== e_ah || seg_al !== e_al ||
                inv_ah !== e_inv || inv_al !== e_inv) begin
                miscompares++;
                $display("FAIL polarity bcd=%0d: ah=%h al=%h inv=%b/%b required ah=%h al=%h inv=%b",
                         bcd[i], seg_ah, seg_al, inv_ah, inv_al, lit_ah[i], e_al, e_inv);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e_al, e_ah;
        logic       e_inv;
        for (int i = 0; i < 16; i++) begin
            apply(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            e_al = q_al.pop_front(); e_ah = q_ah.pop_front(); e_inv = q_inv.pop_front();
            vectors++;
            if (seg_al !== e_al || seg_ah !== e_ah || inv_al !== e_inv || inv_ah !== e_inv) begin
                miscompares++;
                $display("FAIL back_to_back %0d: al=%h ah=%h inv=%b/%b required al=%h ah=%h inv=%b",
                         i, seg_al, seg_ah, inv_al, inv_ah, e_al, e_ah, e_inv);
            end
        end
    endtask

    task automatic test_latency_async_reset();
        logic [6:0] e_al, e_ah;
        logic       e_inv;
        apply(4'd2, 1'b0, 1'b0);
        e_al = q_al.pop_front(); e_ah = q_ah.pop_front(); e_inv = q_inv.pop_front();
        vectors++;
        if (seg_al !== e_al || seg_ah !== e_ah || inv_al !== e_inv) begin
            miscompares++;
            $display("FAIL latency_setup: al=%h ah=%h inv=%b required al=%h ah=%h inv=%b",
                     seg_al, seg_ah, inv_al, e_al, e_ah, e_inv);
        end
        #1;
        BCD_in = 4'd11;
        lamp_test = 1'b1;
        #1;
        vectors++;
        if (seg_al !== e_al || seg_ah !== e_ah || inv_al !== e_inv || inv_ah !== e_inv) begin
            miscompares++;
            $display("FAIL latency_midcycle: al=%h ah=%h inv=%b/%b required al=%h ah=%h inv=%b",
                     seg_al, seg_ah, inv_al, inv_ah, e_al, e_ah, e_inv);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (seg_al !== 7'h7F || seg_ah !== 7'h00 || inv_al !== 1'b0 || inv_ah !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: al=%h ah=%h inv=%b/%b required al=7f ah=00 inv=0",
                     seg_al, seg_ah, inv_al, inv_ah);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lamp_test = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_sweep();
        test_invalid();
        test_overrides();
        test_polarity();
        test_back_to_back();
        test_latency_async_reset();
        vectors++;
        if (q_al.size() != 0 || q_ah.size() != 0 || q_inv.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q_al.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule
